pipe_hazard_ctrl: RTL

Pipeline hazard and control unit for the 5-stage core. It generates the 2-bit stage-control codes consumed by every pipeline register: PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Inputs are the hazard conditions: load-use, taken branch, multi-cycle EX operations and data-memory wait. A small FSM sequences stalls for the iterative multiply/divide unit in EX.

---
 rtl/pipe_hazard_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/squash control for the 5-stage pipeline, including the EX
// multi-cycle sequencer. Control codes: 00 load, 01 squash, 10 stall.
module pipe_hazard_ctrl #(
  parameter int REGW = 5,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            ex_is_load,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_branch_taken,
  input  logic            ex_long_start,
  input  logic [CNTW-1:0] ex_long_cycles,
  input  logic            mem_req,
  input  logic            mem_ready,
  output logic [1:0]      pc_ctr,
  output logic [1:0]      ifid_ctr,
  output logic [1:0]      idex_ctr,
  output logic [1:0]      exmem_ctr,
  output logic [1:0]      memwb_ctr,
  output logic            long_busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [1:0] C_LOAD   = 2'b00;
  localparam logic [1:0] C_SQUASH = 2'b01;
  localparam logic [1:0] C_STALL  = 2'b10;

  logic [0:0]      r_state;
  logic [CNTW-1:0] r_cnt;

  logic w_mem_stall;
  logic w_load_use;
  logic w_long_go;
  logic w_long_stall;

  assign w_mem_stall = mem_req & ~mem_ready;

  assign w_load_use = ex_is_load & (ex_rd != '0) &
                      ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

  // Ops of 0 or 1 cycles never need the sequencer.
  assign w_long_go = ex_long_start & (ex_long_cycles >= CNTW'(2));

  assign w_long_stall = ((r_state == S_IDLE) & w_long_go) |
                        ((r_state == S_BUSY) & (r_cnt != '0));

  always_comb begin
    pc_ctr    = C_LOAD;
    ifid_ctr  = C_LOAD;
    idex_ctr  = C_LOAD;
    exmem_ctr = C_LOAD;
    memwb_ctr = C_LOAD;
    if (rst) begin
      pc_ctr = C_LOAD;
    end else if (w_mem_stall) begin
      pc_ctr    = C_STALL;
      ifid_ctr  = C_STALL;
      idex_ctr  = C_STALL;
      exmem_ctr = C_STALL;
      memwb_ctr = C_SQUASH;
    end else if (w_long_stall) begin
      pc_ctr    = C_STALL;
      ifid_ctr  = C_STALL;
      idex_ctr  = C_STALL;
      exmem_ctr = C_SQUASH;
    end else if (ex_branch_taken) begin
      ifid_ctr  = C_SQUASH;
      idex_ctr  = C_SQUASH;
    end else if (w_load_use) begin
      pc_ctr    = C_STALL;
      ifid_ctr  = C_STALL;
      idex_ctr  = C_SQUASH;
    end
  end

  assign long_busy = ~rst & (r_state == S_BUSY);

  // cnt holds the stall cycles still owed after the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_long_go && !w_mem_stall) begin
            r_state <= S_BUSY;
            r_cnt   <= ex_long_cycles - CNTW'(2);
          end
        end
        S_BUSY: begin
          if (!w_mem_stall) begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CNTW'(1);
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
